cla_bist: RTL and testbench

- Built-in self-test driver and checker for the registered 32-bit carry-lookahead adder (cla_clk).
- Sits on the operand side of the adder: drives a/b/ci, then samples s_cla/co_cla after the adder's pipeline latency.
- Compares each adder result against a behavioural 33-bit sum and reports pass/fail, error count and the first failing vector index.
- Vectors are 4 fixed corner vectors followed by NUM_RANDOM LFSR-generated vectors.

---
 rtl/cla_pkg.sv | 24 ++
 rtl/lfsr32.sv | 26 ++
 rtl/cla_bist.sv | 153 +++++++++++++++
 tb/tb_cla_bist.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder BIST: corner vectors,
// LFSR constants and the controller state encoding.
package cla_pkg;
  localparam int          CLA_WIDTH = 32;
  localparam int          NUM_CORNER = 4;
  // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] CLA_SEED  = 32'h1ACE_B00C;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [CLA_WIDTH-1:0] a;
    logic [CLA_WIDTH-1:0] b;
    logic                 ci;
  } vec_t;

  localparam vec_t CORNER_VEC [NUM_CORNER] = '{
    {32'h0000_0000, 32'h0000_0000, 1'b0},
    {32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
    {32'h0000_FFFF, 32'hFFFF_0000, 1'b0},
    {32'h135F_A562, 32'h3561_4642, 1'b0}
  };
endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous load; reset and load both take the seed.
module lfsr32
  import cla_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] q
);
  logic [31:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)      q_d = seed;
    else if (step) q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_POLY : 32'h0);
  end

  always_ff @(posedge clock) begin
    if (reset) q_q <= seed;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/cla_bist.sv
// BIST driver/checker for a registered adder: drives corner then LFSR vectors
// and compares the delayed adder result against a 33-bit reference sum.
module cla_bist
  import cla_pkg::*;
#(
  parameter int          WIDTH      = CLA_WIDTH,
  parameter int          LATENCY    = 2,
  parameter int          NUM_RANDOM = 64,
  parameter logic [31:0] SEED       = CLA_SEED
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             ci,
  input  logic [WIDTH-1:0] s_cla,
  input  logic             co_cla,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_cnt,
  output logic [15:0]      first_err_idx
);
  localparam logic [15:0] LAST_IDX = 16'(NUM_CORNER + NUM_RANDOM - 1);

  state_t             state_q, state_d;
  logic [15:0]        idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               ci_q, ci_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]        err_q, err_d, first_q, first_d;
  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [WIDTH:0]     exp_pipe_q [LATENCY];
  logic [WIDTH:0]     exp_pipe_d [LATENCY];
  logic [15:0]        idx_pipe_q [LATENCY];
  logic [15:0]        idx_pipe_d [LATENCY];
  logic               drive, lfsr_load, lfsr_step, mismatch;
  logic [31:0]        lfsr_q;

  lfsr32 u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign mismatch = vld_pipe_q[LATENCY-1] &&
                    ({co_cla, s_cla} != exp_pipe_q[LATENCY-1]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    ci_d      = ci_q;
    err_d     = err_q;
    first_d   = first_q;
    drive     = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      IDLE, DONE: if (start) begin
        state_d   = RUN;
        idx_d     = 16'd0;
        err_d     = 16'd0;
        first_d   = 16'hFFFF;
        lfsr_load = 1'b1;
      end
      RUN: begin
        drive = 1'b1;
        if (idx_q < 16'(NUM_CORNER)) begin
          a_d  = WIDTH'(CORNER_VEC[idx_q[1:0]].a);
          b_d  = WIDTH'(CORNER_VEC[idx_q[1:0]].b);
          ci_d = CORNER_VEC[idx_q[1:0]].ci;
        end else begin
          a_d       = WIDTH'(lfsr_q);
          b_d       = WIDTH'({lfsr_q[18:0], lfsr_q[31:19]});
          ci_d      = lfsr_q[0];
          lfsr_step = 1'b1;
        end
        idx_d = idx_q + 16'd1;
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: if (vld_pipe_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Only RUN/DRAIN can have a valid tail, so this never races the start clear
    if (mismatch) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (first_q == 16'hFFFF) first_d = idx_pipe_q[LATENCY-1];
    end

    vld_pipe_d    = LATENCY'({vld_pipe_q, drive});
    exp_pipe_d[0] = {1'b0, a_d} + {1'b0, b_d} + {{WIDTH{1'b0}}, ci_d};
    idx_pipe_d[0] = idx_q;
    for (int i = 1; i < LATENCY; i++) begin
      exp_pipe_d[i] = exp_pipe_q[i-1];
      idx_pipe_d[i] = idx_pipe_q[i-1];
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == 16'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 16'd0;
      a_q        <= '0;
      b_q        <= '0;
      ci_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 16'd0;
      first_q    <= 16'hFFFF;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ci_q       <= ci_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      first_q    <= first_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Payload travels alongside the valid bits; only the valid bits need reset
  always_ff @(posedge clock) begin
    exp_pipe_q <= exp_pipe_d;
    idx_pipe_q <= idx_pipe_d;
  end

  assign a             = a_q;
  assign b             = b_q;
  assign ci            = ci_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_q;
  assign first_err_idx = first_q;
endmodule

// File: tb/tb_cla_bist.sv
// Bench for cla_bist: timeline model of a run checked every cycle, plus a
// corner-only instance and hand-computed literal expectations.
module tb_cla_bist;
  localparam int NR = 64;
  localparam int L  = 2;
  localparam int N  = 4 + NR;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] a, b, s_cla, a0, b0, s0;
  logic        ci, co_cla, busy, done, pass, ci0, co0, busy0, done0, pass0;
  logic [15:0] err_cnt, first_err_idx, err0, first0;
  logic [32:0] r1, r2, r0;
  int          mode = 0;  // 0 good adder, 1 s[16] stuck-at-0, 2 one extra cycle
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  cla_bist #(.LATENCY(L), .NUM_RANDOM(NR)) u_dut (
    .clock(clk), .reset(rst), .start(start), .a(a), .b(b), .ci(ci),
    .s_cla(s_cla), .co_cla(co_cla), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx));

  cla_bist #(.LATENCY(L), .NUM_RANDOM(0)) u_dut0 (
    .clock(clk), .reset(rst), .start(start), .a(a0), .b(b0), .ci(ci0),
    .s_cla(s0), .co_cla(co0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_err_idx(first0));

  always @(posedge clk) begin
    r1 <= {1'b0, a} + {1'b0, b} + {32'd0, ci};
    r2 <= r1;
    r0 <= {1'b0, a0} + {1'b0, b0} + {32'd0, ci0};
  end
  assign {co_cla, s_cla} = (mode == 2) ? r2 : (mode == 1) ? (r1 & ~33'h0_0001_0000) : r1;
  assign {co0, s0} = r0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference vector set
  logic [31:0] va [N];
  logic [31:0] vb [N];
  logic        vci[N];

  function automatic logic [32:0] msum(input int i);
    return {1'b0, va[i]} + {1'b0, vb[i]} + {32'd0, vci[i]};
  endfunction

  // Timeline model: t counts edges since the accepted start
  bit          m_known = 0, m_act = 0, m_done = 0;
  int          m_t = 0, m_err = 0;
  logic [15:0] m_first = 16'hFFFF;
  logic [31:0] m_a = 0, m_b = 0;
  logic        m_ci = 0;
  logic [32:0] m_before = 0;

  function automatic logic [32:0] mobs(input int i);
    if (mode == 1) return msum(i) & ~33'h0_0001_0000;
    if (mode == 2) return (i == 0) ? m_before : msum(i - 1);
    return msum(i);
  endfunction

  initial begin
    forever begin
      logic rs, st;
      @(posedge clk);
      rs = rst;
      st = start;
      #1;
      if (rs) begin
        m_known = 1; m_act = 0; m_done = 0; m_err = 0; m_first = 16'hFFFF;
        m_a = 0; m_b = 0; m_ci = 0;
      end else if (m_known) begin
        if (m_act) begin
          int i;
          m_t++;
          if (m_t <= N) begin m_a = va[m_t-1]; m_b = vb[m_t-1]; m_ci = vci[m_t-1]; end
          i = m_t - L - 1;
          if (i >= 0 && i < N && mobs(i) != msum(i)) begin
            if (m_err < 65535) m_err++;
            if (m_first == 16'hFFFF) m_first = 16'(i);
          end
          if (m_t == N + L + 1) begin m_act = 0; m_done = 1; end
        end else if (st) begin
          m_act = 1; m_t = 0; m_done = 0; m_err = 0; m_first = 16'hFFFF;
          m_before = {1'b0, m_a} + {1'b0, m_b} + {32'd0, m_ci};
        end
      end
      if (m_known) begin
        chk("busy", busy, m_act);
        chk("done", done, m_done);
        chk("pass", pass, m_done && m_err == 0);
        chk("err_cnt", err_cnt, m_err);
        chk("first_err_idx", first_err_idx, m_first);
        chk("a", a, m_a);
        chk("b", b, m_b);
        chk("ci", ci, m_ci);
      end
    end
  end

  task automatic run_wait(input bit noise, input int rst_at, output int cyc,
                          output logic [32:0] v1, output logic [32:0] d0_v3,
                          output logic d0_d6, output logic d0_d7);
    v1 = '0; d0_v3 = '0; d0_d6 = 1'bx; d0_d7 = 1'bx;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; cyc = 0;
    forever begin
      @(negedge clk);
      start = 0;
      cyc++;
      if (cyc == 3) v1 = {co_cla, s_cla};
      if (cyc == 5) d0_v3 = {co0, s0};
      if (cyc == 6) d0_d6 = done0;
      if (cyc == 7) d0_d7 = done0;
      if (cyc == rst_at) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        return;
      end
      if (done || cyc >= 400) break;
      if (noise && $urandom_range(0, 7) == 0) start = 1;
    end
    chk("run_reached_done", done, 1);
  endtask

  initial begin
    int cyc;
    logic [32:0] v1, d3;
    logic d6, d7;
    logic [31:0] s;
    va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000; vci[0] = 0;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0000; vci[1] = 1;
    va[2] = 32'h0000_FFFF; vb[2] = 32'hFFFF_0000; vci[2] = 0;
    va[3] = 32'h135F_A562; vb[3] = 32'h3561_4642; vci[3] = 0;
    s = 32'h1ACE_B00C;
    for (int r = 0; r < NR; r++) begin
      va[4+r] = s;
      vb[4+r] = (s << 13) | (s >> 19);
      vci[4+r] = s[0];
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    end

    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_first", first_err_idx, 16'hFFFF);
    chk("model_vec1", msum(1), 33'h1_0000_0000);
    chk("model_vec3", msum(3), 33'h0_48C0_EBA4);

    // Good adder, both instances
    run_wait(0, -1, cyc, v1, d3, d6, d7);
    chk("runA_len", cyc, 71);
    chk("runA_pass", pass, 1);
    chk("runA_vec1_obs", v1, 33'h1_0000_0000);
    chk("d0_vec3_obs", d3, 33'h0_48C0_EBA4);
    chk("d0_done_at6", d6, 0);
    chk("d0_done_at7", d7, 1);
    chk("d0_pass", pass0, 1);
    chk("d0_err", err0, 0);
    chk("d0_first", first0, 16'hFFFF);

    // Stuck-at on s[16]
    mode = 1;
    run_wait(0, -1, cyc, v1, d3, d6, d7);
    chk("stuck_first", first_err_idx, 2);
    chk("stuck_err_nz", err_cnt != 0, 1);
    chk("stuck_pass", pass, 0);

    // Restart from DONE clears the error state
    mode = 0;
    run_wait(0, -1, cyc, v1, d3, d6, d7);
    chk("redo_pass", pass, 1);
    chk("redo_err", err_cnt, 0);

    // Adder one cycle slower than LATENCY
    rst = 1; @(negedge clk); rst = 0;
    repeat (3) @(negedge clk);
    mode = 2;
    run_wait(0, -1, cyc, v1, d3, d6, d7);
    chk("late_first", first_err_idx, 1);
    chk("late_pass", pass, 0);

    // Reset mid-RUN, then a clean run
    mode = 0;
    run_wait(0, 11, cyc, v1, d3, d6, d7);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err_cnt, 0);
    chk("midrst_done", done, 0);
    run_wait(0, -1, cyc, v1, d3, d6, d7);
    chk("after_rst_pass", pass, 1);

    // Stray start pulses during RUN/DRAIN
    run_wait(1, -1, cyc, v1, d3, d6, d7);
    chk("noise_len", cyc, 71);
    chk("noise_pass", pass, 1);

    // Randomized runs against the model
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      if (!done && !busy) begin rst = 1; @(negedge clk); rst = 0; end
      mode = $urandom_range(0, 2);
      if (mode == 2) begin rst = 1; @(negedge clk); rst = 0; @(negedge clk); end
      run_wait(1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 70)) : -1,
               cyc, v1, d3, d6, d7);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
